// File: rtl/pf_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package pf_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } pf_state_e;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pf_fifo.sv
// Power-of-two circular FIFO with occupancy count and a single-cycle flush.
module pf_fifo
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             wdata_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty_o   = (count_q == {CW{1'b0}});
    assign full_o    = (count_q == FULL_COUNT);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_q];
    // A push into a full FIFO is still legal when the head leaves in the same cycle.
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);

    // Storage, pointers and count; flush empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            rd_q    <= {AW{1'b0}};
            wr_q    <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else if (flush_i) begin
            rd_q    <= {AW{1'b0}};
            wr_q    <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_q <= rd_q + AW'(1'b1);
            end
            count_q <= count_q + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: issues word fetches under a credit limit, buffers the
// returned words for decode, and discards responses made stale by a redirect.
module prefetch_unit
    import pf_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    input  logic               halt,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst_data,
    output logic [XLEN-1:0]    inst_pc,
    input  logic               inst_ready
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            BW      = XLEN + INSTR_W;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

    pf_state_e       state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [CW-1:0]   stale_q;
    logic [CW-1:0]   stale_d;
    logic [CW-1:0]   in_flight_s;
    logic [CW-1:0]   occupancy_s;
    logic [CW:0]     credit_used_s;
    logic            req_fire_s;
    logic            pop_s;
    logic            push_s;
    logic            buf_empty_s;
    logic            buf_full_s;
    logic            pcq_full_s;
    logic            pcq_empty_s;
    logic [XLEN-1:0] rsp_pc_s;
    logic [BW-1:0]   buf_head_s;
    logic            unused_s;

    // Outstanding requests plus buffered words may never exceed the buffer size.
    assign credit_used_s  = {1'b0, in_flight_s} + {1'b0, occupancy_s};
    assign imem_req_valid = (state_q == FETCH) && (credit_used_s < CREDITS);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire_s     = imem_req_valid & imem_req_ready;

    assign inst_valid             = ~buf_empty_s;
    assign {inst_pc, inst_data}   = buf_head_s;
    assign pop_s                  = inst_valid & inst_ready;

    // Next fetch PC, stale-response bookkeeping and the buffer push decision.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        stale_d    = stale_q;
        push_s     = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            stale_d    = in_flight_s + CW'(req_fire_s) - CW'(imem_rsp_valid);
        end else begin
            fetch_pc_d = req_fire_s ? (fetch_pc_q + XLEN'(32'd4)) : fetch_pc_q;
            if (imem_rsp_valid && (stale_q != {CW{1'b0}})) begin
                stale_d = stale_q - CW'(1'b1);
            end else begin
                push_s = imem_rsp_valid;
            end
        end
    end

    // Control FSM: one boot cycle, then fetch until halted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= BOOT;
        end else begin
            case (state_q)
                BOOT:    state_q <= FETCH;
                FETCH:   state_q <= halt ? HALT : FETCH;
                HALT:    state_q <= halt ? HALT : FETCH;
                default: state_q <= BOOT;
            endcase
        end
    end

    // Fetch PC and stale counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            stale_q    <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            stale_q    <= stale_d;
        end
    end

    pf_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect_valid),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({rsp_pc_s, imem_rsp_data}),
        .rdata_o (buf_head_s),
        .count_o (occupancy_s),
        .full_o  (buf_full_s),
        .empty_o (buf_empty_s)
    );

    // In-flight request PCs; its occupancy is the in-flight credit count.
    pf_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pcq (
        .clk     (clk),
        .reset   (reset),
        .flush_i (1'b0),
        .push_i  (req_fire_s),
        .pop_i   (imem_rsp_valid),
        .wdata_i (fetch_pc_q),
        .rdata_o (rsp_pc_s),
        .count_o (in_flight_s),
        .full_o  (pcq_full_s),
        .empty_o (pcq_empty_s)
    );

    assign unused_s = ^{buf_full_s, pcq_full_s, pcq_empty_s, redirect_pc[1:0]};

endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and PC width.
REQ-002 SHALL have parameter DEPTH, default 4, a power of two ≥2: prefetch buffer entries, also the credit limit.
REQ-003 SHALL have parameter RESET_PC, default 0: first fetch address.
REQ-004 SHALL have clock and reset ports:
- clk  in  1  the only clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low.
REQ-005 SHALL have these memory-side ports:
- imem_req_valid  out  1  request to instruction memory.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  one response word is present.
- imem_rsp_data  in  32  instruction word.
REQ-006 SHALL have these control-side ports:
- redirect_valid  in  1  branch or jump taken.
- redirect_pc  in  XLEN  new fetch target.
- halt  in  1  stop issuing new requests.
REQ-007 SHALL have these decode-side ports:
- inst_valid  out  1  buffer head is valid.
- inst_data  out  32  head instruction.
- inst_pc  out  XLEN  head PC.
- inst_ready  in  1  decode consumes the head.

Function
REQ-008 A request SHALL complete on a cycle with imem_req_valid and imem_req_ready both high; fetch_pc then advances by 4 and wraps modulo 2^XLEN.
REQ-009 Memory SHALL return exactly one response per accepted request, in order, with latency ≥1 cycle; the unit SHALL track a queue of in-flight request PCs for this.
REQ-010 imem_req_valid SHALL be high only in FETCH state, and only when in_flight + occupancy < DEPTH (credit rule); the buffer therefore never overflows.
REQ-011 imem_req_valid and imem_req_addr SHALL hold stable until the request is accepted, unless a redirect occurs.
REQ-012 Each non-stale response SHALL be pushed into the buffer together with its request PC.
REQ-013 inst_valid SHALL equal "buffer not empty", and the head SHALL pop on inst_valid and inst_ready.
REQ-014 Push and pop in the same cycle SHALL both complete, including when the buffer is full or empty.
REQ-015 A redirect SHALL take effect in one cycle:
- buffer flushed.
- fetch_pc set to {redirect_pc[XLEN-1:2], 2'b00}.
- stale_cnt set to the in-flight count, including a request accepted in the same cycle.
REQ-016 While stale_cnt > 0, each response SHALL be dropped and SHALL decrement stale_cnt; a response arriving in the redirect cycle itself SHALL be dropped.
REQ-017 A pop in the redirect cycle SHALL count as consumed; inst_valid SHALL be low in the following cycle.
REQ-018 The FSM SHALL have states BOOT, FETCH and HALT:
- BOOT→FETCH after one cycle.
- FETCH→HALT when halt is high.
- HALT→FETCH when halt is low.
REQ-019 In HALT state, in-flight requests SHALL complete and the buffer SHALL keep draining; a redirect SHALL update fetch_pc and flush the buffer while staying in HALT.
REQ-020 The first request after reset SHALL issue in the cycle after the BOOT cycle, with imem_req_addr = RESET_PC.

Reset
REQ-021 While reset = 0 at a clock edge, the unit SHALL load:
- state = BOOT, fetch_pc = RESET_PC.
- Buffer empty; in_flight = 0; stale_cnt = 0.
- imem_req_valid = 0; inst_valid = 0; inst_data = 0; inst_pc = 0.
REQ-022 Reset mid-operation SHALL abandon all in-flight requests; the memory model SHALL be reset in the same cycle.

Structure
REQ-023 The shared package pf_pkg SHALL hold:
- the FSM state enum {BOOT, FETCH, HALT};
- the constant INSTR_W = 32;
- the constant NOP = 32'h00000013.
REQ-024 The buffer SHALL be the sub-module pf_fifo, parametrised by width and DEPTH, with push, pop, full and empty; the top holds the FSM, PC, credit and stale counters.
REQ-025 All counters SHALL be $clog2(DEPTH+1) bits wide.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset release, ready = 1, latency 1, inst_ready = 1 → inst_pc sequence 0x0, 0x4, 0x8, 0xC in back-to-back cycles.
- inst_ready = 0, DEPTH = 4 → exactly 4 requests issued, then imem_req_valid stays 0 until a pop.
- 2 requests in flight, redirect_pc = 0x103 → both responses dropped; next inst_pc = 0x100.
- imem_req_ready = 0 for 3 cycles → imem_req_addr holds 0x8 throughout.
- halt = 1 with 2 in flight → no new requests, 2 instructions delivered; halt = 0 → fetch resumes at the next PC.
- fetch_pc = 0xFFFFFFFC → next request address is 0x00000000.
